// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: access width codes,
// datapath width, and the alignment check.
package dmem_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_BYTE = 2'b01,
    WIDTH_HALF = 2'b10,
    WIDTH_ILL  = 2'b11
  } width_e;

  // Illegal width codes are folded into the misaligned result.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      WIDTH_WORD: return addr_lo != 2'b00;
      WIDTH_HALF: return addr_lo[0];
      WIDTH_BYTE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-port response stage: registers rvalid/err/rdata one cycle after a grant.
module dmem_rsp_reg
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN = dmem_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            gnt_i,
  input  logic            err_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            rvalid_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o
);

  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt_i;
    err_d    = gnt_i & err_i;
    rdata_d  = (gnt_i & ~err_i & load_i) ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority to port 0
// with a forced port-1 grant after MAX_WAIT denied cycles. Optional
// performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned XLEN     = dmem_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [1:0]      p0_width,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  output logic            p0_err,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [1:0]      p1_width,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p1_err,
  output logic            mem_we,
  output logic [1:0]      mem_width,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [31:0]     force_cnt
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]      wait_q, wait_d;
  logic            req0, req1, gnt0, gnt1, force1;
  logic            sel_we, sel_err;
  logic [1:0]      sel_width;
  logic [XLEN-1:0] sel_addr, sel_wdata;

  // Requests are masked while reset is held so no grant leaks out.
  assign req0 = p0_req & reset_n;
  assign req1 = p1_req & reset_n;

  always_comb begin
    force1    = (wait_q == MAX_W);
    gnt1      = req1 & (force1 | ~req0);
    gnt0      = req0 & ~gnt1;
    sel_we    = 1'b0;
    sel_width = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = p1_we;
      sel_width = p1_width;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end else if (gnt0) begin
      sel_we    = p0_we;
      sel_width = p0_width;
      sel_addr  = p0_addr;
      sel_wdata = p0_wdata;
    end
    sel_err = (gnt0 | gnt1) & misaligned(sel_width, sel_addr[1:0]);
    if (!req1 || gnt1)        wait_d = '0;
    else if (wait_q != MAX_W) wait_d = wait_q + 4'd1;
    else                      wait_d = wait_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign mem_we    = sel_we & ~sel_err;
  assign mem_width = sel_width;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  dmem_rsp_reg #(.XLEN(XLEN)) u_rsp0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .gnt_i      (gnt0),
    .err_i      (sel_err),
    .load_i     (~p0_we),
    .mem_rdata_i(mem_rdata),
    .rvalid_o   (p0_rvalid),
    .err_o      (p0_err),
    .rdata_o    (p0_rdata)
  );

  dmem_rsp_reg #(.XLEN(XLEN)) u_rsp1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .gnt_i      (gnt1),
    .err_i      (sel_err),
    .load_i     (~p1_we),
    .mem_rdata_i(mem_rdata),
    .rvalid_o   (p1_rvalid),
    .err_o      (p1_err),
    .rdata_o    (p1_rdata)
  );

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_q, force_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= '0;
      force_q    <= '0;
    end else begin
      if (req0 && req1 && conflict_q != '1)
        conflict_q <= conflict_q + 32'd1;
      if (gnt1 && force1 && req0 && force_q != '1)
        force_q <= force_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
  assign force_cnt    = force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural arbitration/memory model
// checked every cycle; define DMEM_ARB_PERF_EN to cover the perf counters too.
module tb_dmem_arbiter;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [1:0]  p0_width, p1_width;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt, force_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_width(p0_width), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_width(p1_width), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .force_cnt(force_cnt)
`endif
  );

  // External data memory: little-endian bytes, sync write, comb read.
  logic [7:0] mem [0:255];
  logic [7:0] ma;
  always_comb begin
    ma = mem_addr[7:0];
    case (mem_width)
      2'b10:   mem_rdata = {16'h0, mem[ma + 8'd1], mem[ma]};
      2'b01:   mem_rdata = {24'h0, mem[ma]};
      default: mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    endcase
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata[7:0];
        if (mem_width != 2'b01) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
        if (mem_width == 2'b00) begin
          mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
          mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  sh [0:255];
  int          m_wait;
  logic        pv [2];
  logic        pe [2];
  logic [31:0] pd [2];
  logic [31:0] m_conf, m_force;

  function automatic logic [31:0] sh_read(input logic [7:0] a, input logic [1:0] w);
    case (w)
      2'b10:   return {16'h0, sh[a + 8'd1], sh[a]};
      2'b01:   return {24'h0, sh[a]};
      default: return {sh[a + 8'd3], sh[a + 8'd2], sh[a + 8'd1], sh[a]};
    endcase
  endfunction

  initial begin : model
    logic        r0, r1, g0, g1, frc, any, we, bad;
    logic [1:0]  w;
    logic [31:0] a, d;
    for (int i = 0; i < 256; i++) sh[i] = 8'(i);
    m_wait = 0; m_conf = 0; m_force = 0;
    for (int p = 0; p < 2; p++) begin pv[p] = 0; pe[p] = 0; pd[p] = 0; end
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_wait = 0; m_conf = 0; m_force = 0;
        for (int p = 0; p < 2; p++) begin pv[p] = 0; pe[p] = 0; pd[p] = 0; end
      end
      r0 = p0_req & reset_n;
      r1 = p1_req & reset_n;
      frc = (m_wait == MW);
      g1 = r1 && (frc || !r0);
      g0 = r0 && !g1;
      any = g0 || g1;
      we = g1 ? p1_we : p0_we;
      w  = g1 ? p1_width : p0_width;
      a  = g1 ? p1_addr : p0_addr;
      d  = g1 ? p1_wdata : p0_wdata;
      bad = (w == 2'b11) || (w == 2'b00 && a[1:0] != 2'b00) || (w == 2'b10 && a[0]);
      chk("p0_gnt", {31'b0, p0_gnt}, {31'b0, g0});
      chk("p1_gnt", {31'b0, p1_gnt}, {31'b0, g1});
      chk("mem_we", {31'b0, mem_we}, {31'b0, any && we && !bad});
      chk("mem_width", {30'b0, mem_width}, any ? {30'b0, w} : 32'h0);
      chk("mem_addr", mem_addr, any ? a : 32'h0);
      chk("mem_wdata", mem_wdata, any ? d : 32'h0);
      chk("p0_rvalid", {31'b0, p0_rvalid}, {31'b0, pv[0]});
      chk("p1_rvalid", {31'b0, p1_rvalid}, {31'b0, pv[1]});
      chk("p0_err", {31'b0, p0_err}, {31'b0, pe[0]});
      chk("p1_err", {31'b0, p1_err}, {31'b0, pe[1]});
      if (pv[0]) chk("p0_rdata", p0_rdata, pd[0]);
      if (pv[1]) chk("p1_rdata", p1_rdata, pd[1]);
`ifdef DMEM_ARB_PERF_EN
      chk("conflict_cnt", conflict_cnt, m_conf);
      chk("force_cnt", force_cnt, m_force);
      if (r0 && r1 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
      if (g1 && frc && r0 && m_force != 32'hFFFF_FFFF) m_force = m_force + 1;
`endif
      pv[0] = g0; pv[1] = g1;
      pe[0] = g0 && bad; pe[1] = g1 && bad;
      pd[0] = (g0 && !bad && !we) ? sh_read(a[7:0], w) : 32'h0;
      pd[1] = (g1 && !bad && !we) ? sh_read(a[7:0], w) : 32'h0;
      if (any && we && !bad) begin
        sh[a[7:0]] = d[7:0];
        if (w != 2'b01) sh[a[7:0] + 8'd1] = d[15:8];
        if (w == 2'b00) begin
          sh[a[7:0] + 8'd2] = d[23:16];
          sh[a[7:0] + 8'd3] = d[31:24];
        end
      end
      m_wait = (r1 && !g1) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic we, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_we = we; p0_width = w; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic we, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    p1_req = r; p1_we = we; p1_width = w; p1_addr = a; p1_wdata = d;
  endtask

  initial begin : stim
    logic [9:0] pat;
    reset_n = 1'b0;
    set0(0, 0, 2'b00, 0, 0);
    set1(0, 0, 2'b00, 0, 0);
    repeat (3) step();
    @(negedge clk);
    chk("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // Store then load back through port 0.
    set0(1, 1, 2'b00, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_st_gnt", {31'b0, p0_gnt}, 32'h1);
    step();
    set0(1, 0, 2'b00, 32'h10, 32'h0);
    step();
    set0(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("t1_rvalid", {31'b0, p0_rvalid}, 32'h1);
    chk("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("t1_err", {31'b0, p0_err}, 32'h0);
    step();

    // Contention: p1 forced every fifth cycle.
    set0(1, 0, 2'b00, 32'h0, 32'h0);
    set1(1, 0, 2'b00, 32'h4, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = p1_gnt;
      step();
    end
    chk("t2_pattern", {22'b0, pat}, 32'h210);
    set0(0, 0, 2'b00, 0, 0);
    set1(0, 0, 2'b00, 0, 0);
    step();

    // Misaligned halfword store on port 1 must not write.
    set1(1, 1, 2'b10, 32'h3, 32'h0000_1234);
    @(negedge clk);
    chk("t3_gnt", {31'b0, p1_gnt}, 32'h1);
    chk("t3_mem_we", {31'b0, mem_we}, 32'h0);
    step();
    set1(1, 0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("t3_err", {31'b0, p1_err}, 32'h1);
    step();
    set1(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("t3_rdata", p1_rdata, 32'h0302_0100);
    step();

    // Illegal width on port 0.
    set0(1, 0, 2'b11, 32'h20, 32'h0);
    step();
    set0(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("t4_err", {31'b0, p0_err}, 32'h1);
    chk("t4_rdata", p0_rdata, 32'h0);
    step();

    // Back-to-back byte stores on port 1.
    for (int i = 0; i < 4; i++) begin
      set1(1, 1, 2'b01, 32'h40 + 32'(i), 32'hAA + 32'(i) * 32'h11);
      @(negedge clk);
      chk("t5_gnt", {31'b0, p1_gnt}, 32'h1);
      if (i > 0) chk("t5_rvalid", {31'b0, p1_rvalid}, 32'h1);
      step();
    end
    set1(1, 0, 2'b00, 32'h40, 32'h0);
    step();
    set1(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("t5_rdata", p1_rdata, 32'hDDCC_BBAA);
    step();

    // Mixed traffic: misaligned word on p0 alongside a byte load on p1.
    set0(1, 0, 2'b00, 32'h2, 32'h0);
    set1(1, 0, 2'b01, 32'h41, 32'h0);
    step();
    set0(0, 0, 2'b00, 0, 0);
    step();
    set1(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("mix_p1_rdata", p1_rdata, 32'h0000_00BB);
    step();

    // Reset while a load response is pending.
    set0(1, 0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    chk("t6_gnt", {31'b0, p0_gnt}, 32'h1);
    #1;
    reset_n = 1'b0;
    set0(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rvalid", {31'b0, p0_rvalid}, 32'h0);
      chk("t6_rdata", p0_rdata, 32'h0);
    end
`ifdef DMEM_ARB_PERF_EN
    chk("t6_conflict", conflict_cnt, 32'h0);
`endif
    step();
    reset_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
